list_prefetch_buffer: RTL and testbench

- Sits directly downstream of a lazy list producer (enumerator, concat, cons) on the req/ack list-stream protocol.
- Re-exposes that list on the same protocol to its own consumer.
- Prefetches up to DEPTH elements ahead into a FIFO, so consumer pulls normally complete in 1 cycle instead of the producer's round-trip.
- Records the end-of-list marker and replays it on every later pull.

---
 rtl/list_stream_pkg.sv | 18 +
 rtl/list_prefetch_buffer_if.sv | 15 +
 rtl/list_fifo_mem.sv | 79 +++++++
 rtl/list_prefetch_buffer.sv | 154 +++++++++++++++
 tb/tb_list_prefetch_buffer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/list_stream_pkg.sv
// Shared types and constants for the list-stream prefetch buffer.
// Holds the default element width, the fetch FSM encoding and the level-width helper.
package list_stream_pkg;

   localparam int LIST_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   // Occupancy counter needs one extra bit so that a full FIFO (level == DEPTH) is representable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/list_prefetch_buffer_if.sv
// req/ack list-stream link: the consumer raises req, the producer answers with a one-cycle ack
// carrying value/value_valid (value_valid=0 marks end of list).
interface list_prefetch_buffer_if
   import list_stream_pkg::*;
#(
   parameter int WIDTH = LIST_WIDTH
);
   logic             req;
   logic             ack;
   logic [WIDTH-1:0] value;
   logic             value_valid;

   modport master (input req, output ack, output value, output value_valid);
   modport slave  (output req, input ack, input value, input value_valid);
endinterface

// File: rtl/list_fifo_mem.sv
// Plain DEPTH x WIDTH circular buffer with push/pop/flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module list_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push_s;
   logic             do_pop_s;

   // Next-state for storage, pointers and occupancy; overflow/underflow requests are dropped.
   always_comb begin
      do_push_s = push & (level_q != LVL_W'(DEPTH));
      do_pop_s  = pop & (level_q != {LVL_W{1'b0}});
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         level_d  = {LVL_W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Storage and pointer registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         level_q  <= {LVL_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/list_prefetch_buffer.sv
// Prefetching FIFO between a lazy list producer (src) and its consumer (dst), replaying end-of-list.
// Optional LIST_PREFETCH_BYPASS_EN: a cold-start element goes straight to the consumer, skipping the FIFO.
module list_prefetch_buffer
   import list_stream_pkg::*;
#(
   parameter int WIDTH = LIST_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ready,
   list_prefetch_buffer_if.slave  src,
   list_prefetch_buffer_if.master dst,
   output logic [$clog2(DEPTH):0] level
);
   localparam int LVL_W = level_width(DEPTH);
`ifdef LIST_PREFETCH_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   fetch_state_t     state_q, state_d;
   logic             end_seen_q, end_seen_d;
   logic             pending_q, pending_d;
   logic             last_req_q, last_req_d;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             value_valid_q, value_valid_d;

   logic             src_req_s;
   logic             edge_s, want_s, src_hit_s, bypass_s;
   logic             push_s, pop_s, flush_s, fifo_empty_s, fifo_room_s;
   logic [WIDTH-1:0] fifo_head_s;
   logic [LVL_W-1:0] fifo_level_s;

   list_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush_s),
      .push      (push_s),
      .push_data (src.value),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .level     (fifo_level_s)
   );

   assign flush_s      = ~ready;
   assign fifo_empty_s = (fifo_level_s == {LVL_W{1'b0}});
   assign fifo_room_s  = (fifo_level_s < LVL_W'(DEPTH));
   assign edge_s       = dst.req & ~last_req_q;
   assign want_s       = pending_q | edge_s;
   assign src_hit_s    = (state_q == REQ) & src.ack;

   // Fetch FSM next state; only one upstream fetch is ever in flight, so the reserved slot cannot overflow.
   always_comb begin
      state_d = state_q;
      if (!ready) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!end_seen_q && fifo_room_s) state_d = REQ;
               else                            state_d = IDLE;
            end
            REQ: begin
               if (src.ack) state_d = DROP;
               else         state_d = REQ;
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Fetch FSM outputs.
   always_comb begin
      src_req_s = (state_q == REQ);
   end

   // Consumer service: buffered data first, then the end marker, else hold the request pending.
   always_comb begin
      ack_d         = 1'b0;
      value_d       = value_q;
      value_valid_d = value_valid_q;
      pending_d     = pending_q;
      end_seen_d    = end_seen_q;
      last_req_d    = last_req_q;
      pop_s         = 1'b0;
      push_s        = 1'b0;
      bypass_s      = 1'b0;
      if (!ready) begin
         last_req_d    = 1'b0;
         pending_d     = 1'b0;
         end_seen_d    = 1'b0;
         value_valid_d = 1'b0;
      end else begin
         last_req_d = dst.req;
         if (want_s) begin
            if (!fifo_empty_s) begin
               ack_d         = 1'b1;
               value_d       = fifo_head_s;
               value_valid_d = 1'b1;
               pop_s         = 1'b1;
               pending_d     = 1'b0;
            end else if (end_seen_q) begin
               ack_d         = 1'b1;
               value_valid_d = 1'b0;
               pending_d     = 1'b0;
            end else if (BYPASS_EN && src_hit_s) begin
               ack_d         = 1'b1;
               value_d       = src.value_valid ? src.value : value_q;
               value_valid_d = src.value_valid;
               pending_d     = 1'b0;
               bypass_s      = 1'b1;
            end else begin
               pending_d = 1'b1;
            end
         end else begin
            pending_d = 1'b0;
         end
         push_s     = src_hit_s & src.value_valid & ~bypass_s;
         end_seen_d = end_seen_q | (src_hit_s & ~src.value_valid);
      end
   end

   // State register for the FSM and consumer-side flops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         end_seen_q    <= 1'b0;
         pending_q     <= 1'b0;
         last_req_q    <= 1'b0;
         ack_q         <= 1'b0;
         value_q       <= {WIDTH{1'b0}};
         value_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         end_seen_q    <= end_seen_d;
         pending_q     <= pending_d;
         last_req_q    <= last_req_d;
         ack_q         <= ack_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
      end
   end

   assign src.req         = src_req_s;
   assign dst.ack         = ack_q;
   assign dst.value       = value_q;
   assign dst.value_valid = value_valid_q;
   assign level           = fifo_level_s;

endmodule

// File: tb/tb_list_prefetch_buffer.sv
// Directed bench for list_prefetch_buffer: an enumerator-style upstream, a queue-level reference model
// checked every cycle, and hand-computed expectations for each scenario.
module tb_list_prefetch_buffer;
   import list_stream_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef LIST_PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic ready = 1'b0;
   logic [$clog2(DEPTH):0] level;

   list_prefetch_buffer_if #(.WIDTH(WIDTH)) src_if ();
   list_prefetch_buffer_if #(.WIDTH(WIDTH)) dst_if ();

   list_prefetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .ready (ready),
      .src   (src_if.slave),
      .dst   (dst_if.master),
      .level (level)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever #5 clock = ~clock;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Upstream enumerator: answers each src_req rising edge after p_lat cycles.
   int p_min = -2, p_step = 3, p_max = 7, p_lat = 1;
   bit p_empty = 1'b0;
   int p_cur = -2, p_wait = -1, src_rises = 0, src_ack_cyc = 0;
   bit p_prev = 1'b0;

   initial begin
      src_if.ack = 1'b0;
      src_if.value = 8'h00;
      src_if.value_valid = 1'b0;
      forever begin
         @(negedge clock);
         src_if.ack = 1'b0;
         if (reset || !ready) begin
            p_cur = p_min; p_wait = -1; p_prev = 1'b0;
         end else begin
            if (src_if.req && !p_prev) begin
               p_wait = p_lat;
               src_rises++;
            end else if (p_wait > 0) begin
               p_wait--;
            end
            if (p_wait == 0) begin
               src_if.ack = 1'b1;
               src_ack_cyc = cyc;
               if (p_empty || p_cur > p_max) begin
                  src_if.value_valid = 1'b0;
                  src_if.value = 8'h00;
               end else begin
                  src_if.value_valid = 1'b1;
                  src_if.value = 8'(p_cur);
                  p_cur += p_step;
               end
               p_wait = -1;
            end
            p_prev = src_if.req;
         end
      end
   end

   // Reference model: list contents as a queue, plus the request/fetch rules.
   int m_q[$];
   bit m_end = 0, m_pend = 0, m_last = 0, m_ack = 0, m_vv = 0;
   logic [7:0] m_value = 8'h00;
   int m_fetch = 0; // 0 idle, 1 requesting, 2 dropped

   initial begin : cmp
      logic s_rst, s_rdy, s_req, s_ack, s_vv;
      logic [7:0] s_val;
      int osz;
      bit oend, edg, want, got, byp;
      forever begin
         @(posedge clock);
         s_rst = reset; s_rdy = ready; s_req = dst_if.req;
         s_ack = src_if.ack; s_vv = src_if.value_valid; s_val = src_if.value;
         #1;
         if (s_rst) begin
            m_q.delete(); m_end = 0; m_pend = 0; m_last = 0; m_ack = 0; m_vv = 0;
            m_value = 8'h00; m_fetch = 0;
         end else if (!s_rdy) begin
            m_q.delete(); m_end = 0; m_pend = 0; m_last = 0; m_ack = 0; m_vv = 0;
            m_fetch = 0;
         end else begin
            osz = m_q.size(); oend = m_end;
            edg = s_req && !m_last;
            want = m_pend || edg;
            got = (m_fetch == 1) && s_ack;
            byp = 0; m_ack = 0;
            if (want) begin
               if (m_q.size() > 0) begin
                  m_value = 8'(m_q.pop_front()); m_vv = 1; m_ack = 1; m_pend = 0;
               end else if (m_end) begin
                  m_vv = 0; m_ack = 1; m_pend = 0;
               end else if (BYP && got) begin
                  m_ack = 1; m_vv = s_vv; m_pend = 0; byp = 1;
                  if (s_vv) m_value = s_val;
               end else begin
                  m_pend = 1;
               end
            end
            if (got && s_vv && !byp) m_q.push_back(int'(s_val));
            if (got && !s_vv) m_end = 1;
            case (m_fetch)
               0: if (!oend && osz < DEPTH) m_fetch = 1;
               1: if (s_ack) m_fetch = 2;
               default: m_fetch = 0;
            endcase
            m_last = s_req;
         end
         check("cyc_ack", int'(dst_if.ack), int'(m_ack));
         check("cyc_value_valid", int'(dst_if.value_valid), int'(m_vv));
         check("cyc_value", int'(dst_if.value), int'(m_value));
         check("cyc_level", int'(level), m_q.size());
         check("cyc_src_req", int'(src_if.req), (m_fetch == 1) ? 1 : 0);
      end
   end

   int lvl_peak = 0;
   initial forever begin
      @(negedge clock);
      if (int'(level) > lvl_peak) lvl_peak = int'(level);
   end

   int ack_cyc = 0;

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pull(output int val, output bit vv, output int lat);
      bit got;
      @(negedge clock);
      dst_if.req = 1'b1;
      got = 0; val = 0; vv = 0; lat = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clock);
         if (dst_if.ack) begin
            got = 1; val = int'($signed(dst_if.value)); vv = dst_if.value_valid;
            lat = k; ack_cyc = cyc;
         end
      end
      check("pull_ack_seen", int'(got), 1);
      dst_if.req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int v, lat, r0, n_ack;
      bit vv, found;
      int exp_v[6];
      int exp_vv[6];
      exp_v  = '{-2, 1, 4, 7, 7, 7};
      exp_vv = '{1, 1, 1, 1, 0, 0};
      dst_if.req = 1'b0;

      idle(2);
      check("reset_src_req", int'(src_if.req), 0);
      check("reset_ack", int'(dst_if.ack), 0);
      check("reset_value", int'(dst_if.value), 0);
      check("reset_value_valid", int'(dst_if.value_valid), 0);
      check("reset_level", int'(level), 0);
      reset = 1'b0;
      idle(1);

      // Finite enumerator -2..7 step 3, consumer silent first so the FIFO fills.
      lvl_peak = 0; r0 = src_rises;
      ready = 1'b1;
      idle(30);
      check("enum_full_level", int'(level), 4);
      check("enum_full_src_req", int'(src_if.req), 0);
      check("enum_fetches_before_pull", src_rises - r0, 4);
      for (int i = 0; i < 6; i++) begin
         pull(v, vv, lat);
         check($sformatf("enum_value_%0d", i), v, exp_v[i]);
         check($sformatf("enum_valid_%0d", i), int'(vv), exp_vv[i]);
         idle(3);
      end
      idle(10);
      check("enum_fetches_total", src_rises - r0, 5);
      check("enum_level_peak", lvl_peak, 4);
      ready = 1'b0;
      idle(2);
      check("flush_level", int'(level), 0);
      check("flush_value_valid", int'(dst_if.value_valid), 0);

      // Infinite upstream: FIFO fills and fetching stops; one pull refills one slot.
      p_max = 100000;
      ready = 1'b1;
      idle(40);
      check("inf_level_full", int'(level), 4);
      check("inf_src_req_idle", int'(src_if.req), 0);
      pull(v, vv, lat);
      check("inf_value", v, -2);
      check("inf_latency", lat, 1);
      check("inf_level_after_pop", int'(level), 3);
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(negedge clock);
         if (int'(level) == 4) found = 1;
      end
      check("inf_refill", int'(found), 1);
      ready = 1'b0;
      idle(2);

      // Cold start: pull right after ready rises.
      ready = 1'b1;
      pull(v, vv, lat);
      check("cold_value", v, -2);
      check("cold_valid", int'(vv), 1);
      check("cold_latency_from_src_ack", ack_cyc - src_ack_cyc, BYP ? 1 : 2);
      ready = 1'b0;
      idle(2);

      // Empty upstream: every pull reports end of list.
      p_empty = 1'b1; r0 = src_rises;
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pull(v, vv, lat);
         check($sformatf("empty_valid_%0d", i), int'(vv), 0);
         idle(2);
      end
      check("empty_level", int'(level), 0);
      check("empty_fetches", src_rises - r0, 1);
      ready = 1'b0;
      p_empty = 1'b0;
      idle(2);

      // Drop ready mid-fetch with two elements buffered.
      ready = 1'b1;
      pull(v, vv, lat);
      check("drop_first_value", v, -2);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clock);
         if (int'(level) == 2 && src_if.req) found = 1;
      end
      check("drop_reached_level2_req", int'(found), 1);
      ready = 1'b0;
      @(negedge clock);
      check("drop_src_req", int'(src_if.req), 0);
      check("drop_level", int'(level), 0);
      check("drop_ack", int'(dst_if.ack), 0);
      check("drop_value_valid", int'(dst_if.value_valid), 0);
      ready = 1'b1;
      pull(v, vv, lat);
      check("drop_restart_value", v, -2);
      ready = 1'b0;
      idle(2);

      // Asynchronous reset while a pull is pending.
      p_lat = 6;
      ready = 1'b1;
      @(negedge clock);
      dst_if.req = 1'b1;
      @(negedge clock);
      #2;
      reset = 1'b1;
      dst_if.req = 1'b0;
      #1;
      check("areset_src_req", int'(src_if.req), 0);
      check("areset_ack", int'(dst_if.ack), 0);
      check("areset_value", int'(dst_if.value), 0);
      check("areset_value_valid", int'(dst_if.value_valid), 0);
      check("areset_level", int'(level), 0);
      @(negedge clock);
      reset = 1'b0;
      n_ack = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (dst_if.ack) n_ack++;
      end
      check("areset_no_spurious_ack", n_ack, 0);
      pull(v, vv, lat);
      check("areset_next_value", v, -2);
      check("areset_next_latency", lat, 1);
      p_lat = 1;
      ready = 1'b0;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
